// File: rtl/vend_controller_if.sv
// Signal bundle between the coin/keypad front end, the dispenser mechanics and vend_controller.
// The cancel wire only exists when VEND_CANCEL_EN is defined.
interface vend_controller_if #(
  parameter int CREDIT_W = 5
);
  logic                coin_n;
  logic                coin_d;
  logic                coin_q;
  logic                sel_valid;
  logic [1:0]          sel_id;
  logic                vend_ack;
  logic                change_ack;
`ifdef VEND_CANCEL_EN
  logic                cancel;
`endif
  logic                vend_req;
  logic [1:0]          vend_id;
  logic                change_req;
  logic                coin_reject;
  logic                sel_deny;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
`ifdef VEND_CANCEL_EN
    output cancel,
`endif
    output coin_n, coin_d, coin_q, sel_valid, sel_id, vend_ack, change_ack,
    input  vend_req, vend_id, change_req, coin_reject, sel_deny, credit, busy
  );

  modport slave (
`ifdef VEND_CANCEL_EN
    input  cancel,
`endif
    input  coin_n, coin_d, coin_q, sel_valid, sel_id, vend_ack, change_ack,
    output vend_req, vend_id, change_req, coin_reject, sel_deny, credit, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Credit-and-dispense sequencer: accumulates coin credit, dispenses via req/ack, refunds change in nickels.
// Define VEND_CANCEL_EN to add a cancel input that refunds all credit from ACCEPT.
module vend_controller #(
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 7
) (
  input logic              clk,
  input logic              rstn,
  vend_controller_if.slave bus
);

  localparam int CW1 = CREDIT_W + 1;

  typedef enum logic [1:0] {ACCEPT, VEND, CHANGE} state_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_q, credit_nx;
  logic                vend_req_q, vend_req_nx;
  logic [1:0]          vend_id_q, vend_id_nx;
  logic                change_req_q, change_req_nx;
  logic                coin_reject_q, coin_reject_nx;
  logic                sel_deny_q, sel_deny_nx;
  logic                busy_q;

  logic [1:0]          coin_cnt;
  logic [CW1-1:0]      coin_val;
  logic [CW1-1:0]      credit_sum;
  logic [CREDIT_W-1:0] price;
  logic                cancel_req;

  // Any simultaneous coins are rejected as a group, so only a lone pulse carries a value.
  assign coin_cnt   = {1'b0, bus.coin_n} + {1'b0, bus.coin_d} + {1'b0, bus.coin_q};
  assign credit_sum = {1'b0, credit_q} + coin_val;

`ifdef VEND_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  always_comb begin
    coin_val = '0;
    case ({bus.coin_n, bus.coin_d, bus.coin_q})
      3'b100:  coin_val = CW1'(1);
      3'b010:  coin_val = CW1'(2);
      3'b001:  coin_val = CW1'(5);
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    price = CREDIT_W'(PRICE0);
    case (bus.sel_id)
      2'd0:    price = CREDIT_W'(PRICE0);
      2'd1:    price = CREDIT_W'(PRICE1);
      2'd2:    price = CREDIT_W'(PRICE2);
      default: price = CREDIT_W'(PRICE3);
    endcase
  end

  always_comb begin
    state_nx       = state;
    credit_nx      = credit_q;
    vend_req_nx    = vend_req_q;
    vend_id_nx     = vend_id_q;
    change_req_nx  = change_req_q;
    coin_reject_nx = 1'b0;
    sel_deny_nx    = 1'b0;
    case (state)
      ACCEPT: begin
        if (bus.sel_valid && credit_q >= price) begin
          credit_nx      = credit_q - price;
          vend_id_nx     = bus.sel_id;
          vend_req_nx    = 1'b1;
          state_nx       = VEND;
          coin_reject_nx = (coin_cnt != 2'd0);
        end else if (!bus.sel_valid && cancel_req && credit_q != '0) begin
          change_req_nx  = 1'b1;
          state_nx       = CHANGE;
          coin_reject_nx = (coin_cnt != 2'd0);
        end else begin
          // A refused selection still lets a same-cycle coin through, judged on pre-coin credit.
          sel_deny_nx = bus.sel_valid;
          if (coin_cnt == 2'd1 && credit_sum <= CW1'(MAX_CREDIT))
            credit_nx = credit_sum[CREDIT_W-1:0];
          else if (coin_cnt != 2'd0)
            coin_reject_nx = 1'b1;
        end
      end
      VEND: begin
        coin_reject_nx = (coin_cnt != 2'd0);
        if (bus.vend_ack) begin
          vend_req_nx = 1'b0;
          if (credit_q != '0) begin
            change_req_nx = 1'b1;
            state_nx      = CHANGE;
          end else begin
            state_nx = ACCEPT;
          end
        end
      end
      CHANGE: begin
        coin_reject_nx = (coin_cnt != 2'd0);
        if (change_req_q && bus.change_ack) begin
          if (credit_q != '0)
            credit_nx = credit_q - CREDIT_W'(1);
          if (credit_q <= CREDIT_W'(1)) begin
            change_req_nx = 1'b0;
            state_nx      = ACCEPT;
          end
        end
      end
      default: state_nx = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ACCEPT;
      credit_q      <= '0;
      vend_req_q    <= 1'b0;
      vend_id_q     <= 2'd0;
      change_req_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_deny_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      credit_q      <= credit_nx;
      vend_req_q    <= vend_req_nx;
      vend_id_q     <= vend_id_nx;
      change_req_q  <= change_req_nx;
      coin_reject_q <= coin_reject_nx;
      sel_deny_q    <= sel_deny_nx;
      busy_q        <= (state_nx != ACCEPT);
    end
  end

  assign bus.credit      = credit_q;
  assign bus.vend_req    = vend_req_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.change_req  = change_req_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_deny    = sel_deny_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: each scenario queues stimulus/expectation pairs and checks per cycle.
// Expected output word layout: {credit[4:0], vend_req, vend_id[1:0], change_req, coin_reject, sel_deny, busy}.
module tb_vend_controller;

  typedef struct packed {
    logic [2:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       vend_ack;
    logic       change_ack;
    logic       cancel;
  } stim_t;

  typedef struct packed {
    logic [4:0] credit;
    logic       vend_req;
    logic [1:0] vend_id;
    logic       change_req;
    logic       coin_reject;
    logic       sel_deny;
    logic       busy;
  } out_t;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] NCK  = 3'b100;
  localparam logic [2:0] DIM  = 3'b010;
  localparam logic [2:0] QTR  = 3'b001;

  logic clk = 1'b0;
  logic rstn;

  int    vectors     = 0;
  int    miscompares = 0;
  stim_t plan_stim[$];
  out_t  plan_exp[$];
  out_t  exp_q[$];

  vend_controller_if #(.CREDIT_W(5)) bus ();

  vend_controller dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t s(input logic [2:0] coin, input logic sv, input logic [1:0] id,
                              input logic va, input logic ca, input logic cn);
    return {coin, sv, id, va, ca, cn};
  endfunction

  function automatic out_t e(input int cr, input logic vr, input logic [1:0] vid, input logic chr,
                             input logic rj, input logic dn, input logic bz);
    return {5'(cr), vr, vid, chr, rj, dn, bz};
  endfunction

  function automatic out_t observe();
    return {bus.credit, bus.vend_req, bus.vend_id, bus.change_req, bus.coin_reject, bus.sel_deny, bus.busy};
  endfunction

  task automatic drive(input stim_t st);
    bus.coin_n     = st.coin[2];
    bus.coin_d     = st.coin[1];
    bus.coin_q     = st.coin[0];
    bus.sel_valid  = st.sel_valid;
    bus.sel_id     = st.sel_id;
    bus.vend_ack   = st.vend_ack;
    bus.change_ack = st.change_ack;
`ifdef VEND_CANCEL_EN
    bus.cancel     = st.cancel;
`endif
  endtask

  task automatic add(input stim_t st, input out_t ex);
    plan_stim.push_back(st);
    plan_exp.push_back(ex);
  endtask

  task automatic test_reset();
    out_t got, want;
    int   step = 0;
    rstn = 1'b0;
    drive(s(NONE, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    vectors++;
    if (got !== e(0, 0, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("[TB] FAIL test_reset held: got %b, expected %b", got, e(0, 0, 0, 0, 0, 0, 0));
    end
    rstn = 1'b1;
    add(s(NONE, 0, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 0, 0, 1, 1, 0), e(0, 0, 0, 0, 0, 0, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_reset step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask

  task automatic test_exact_purchase();
    out_t got, want;
    int   step = 0;
    add(s(NCK,  0, 0, 0, 0, 0), e(1, 0, 0, 0, 0, 0, 0));
    add(s(DIM,  0, 0, 0, 0, 0), e(3, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 1, 0, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 1));
    add(s(NONE, 0, 0, 1, 0, 0), e(0, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 0, 0, 0, 1, 0), e(0, 0, 0, 0, 0, 0, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_exact_purchase step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask

  task automatic test_change();
    out_t got, want;
    int   step = 0;
    add(s(QTR,  0, 0, 0, 0, 0), e(5, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 1, 1, 0, 0, 0), e(1, 1, 1, 0, 0, 0, 1));
    add(s(NONE, 0, 0, 1, 0, 0), e(1, 0, 1, 1, 0, 0, 1));
    repeat (3) add(s(NONE, 0, 0, 0, 0, 0), e(1, 0, 1, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 1, 0), e(0, 0, 1, 0, 0, 0, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_change step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask

  task automatic test_deny_and_vend_reject();
    out_t got, want;
    int   step = 0;
    add(s(NCK,  0, 0, 0, 0, 0), e(1, 0, 1, 0, 0, 0, 0));
    add(s(NONE, 1, 0, 0, 0, 0), e(1, 0, 1, 0, 0, 1, 0));
    add(s(DIM,  1, 3, 0, 0, 0), e(3, 0, 1, 0, 0, 1, 0));
    add(s(NONE, 1, 0, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 1));
    add(s(NCK,  0, 0, 0, 0, 0), e(0, 1, 0, 0, 1, 0, 1));
    add(s(NONE, 1, 1, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 1));
    add(s(NONE, 0, 0, 1, 0, 0), e(0, 0, 0, 0, 0, 0, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_deny_and_vend_reject step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask

  task automatic test_credit_limit();
    out_t got, want;
    int   step = 0;
    for (int i = 1; i <= 4; i++)
      add(s(QTR, 0, 0, 0, 0, 0), e(5 * i, 0, 0, 0, 0, 0, 0));
    add(s(NCK,  0, 0, 0, 0, 0), e(20, 0, 0, 0, 1, 0, 0));
    add(s(3'b110, 0, 0, 0, 0, 0), e(20, 0, 0, 0, 1, 0, 0));
    add(s(NONE, 0, 0, 0, 0, 0), e(20, 0, 0, 0, 0, 0, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_credit_limit step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset_mid_vend();
    out_t got, want;
    int   step = 0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    add(s(DIM,  0, 0, 0, 0, 0), e(2, 0, 0, 0, 0, 0, 0));
    add(s(DIM,  0, 0, 0, 0, 0), e(4, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 1, 0, 0, 0, 0), e(1, 1, 0, 0, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 0, 0), e(1, 1, 0, 0, 0, 0, 1));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_reset_mid_vend step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    rstn = 1'b0;
    #1;
    got = observe();
    vectors++;
    if (got !== e(0, 0, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("[TB] FAIL test_reset_mid_vend async: got %b, expected %b", got, e(0, 0, 0, 0, 0, 0, 0));
    end
    #1;
    rstn = 1'b1;
    add(s(NONE, 1, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 1, 0));
    add(s(NCK,  0, 0, 0, 0, 0), e(1, 0, 0, 0, 0, 0, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_reset_mid_vend post step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask

`ifdef VEND_CANCEL_EN
  task automatic test_cancel();
    out_t got, want;
    int   step = 0;
    add(s(NONE, 0, 0, 0, 0, 1), e(1, 0, 0, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 1, 0), e(0, 0, 0, 0, 0, 0, 0));
    add(s(DIM,  0, 0, 0, 0, 0), e(2, 0, 0, 0, 0, 0, 0));
    add(s(DIM,  0, 0, 0, 0, 0), e(4, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 0, 0, 0, 0, 1), e(4, 0, 0, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 1, 1), e(3, 0, 0, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 0, 0), e(3, 0, 0, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 1, 0), e(2, 0, 0, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 1, 0), e(1, 0, 0, 1, 0, 0, 1));
    add(s(NONE, 0, 0, 0, 1, 0), e(0, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 0, 0, 0, 0, 1), e(0, 0, 0, 0, 0, 0, 0));
    add(s(NCK,  0, 0, 0, 0, 0), e(1, 0, 0, 0, 0, 0, 0));
    add(s(NONE, 1, 0, 0, 0, 1), e(1, 0, 0, 0, 0, 1, 0));
    while (plan_stim.size() != 0) begin
      drive(plan_stim.pop_front());
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL test_cancel step %0d: got %b, expected %b", step, got, want);
      end
      step++;
    end
    drive(s(NONE, 0, 0, 0, 0, 0));
  endtask
`endif

  initial begin
    test_reset();
    test_exact_purchase();
    test_change();
    test_deny_and_vend_reject();
    test_credit_limit();
    test_reset_mid_vend();
`ifdef VEND_CANCEL_EN
    test_cancel();
`else
    $display("[TB] test_cancel skipped, VEND_CANCEL_EN not defined");
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
